// File: rtl/ddr3_test_pkg.sv
// Shared definitions for the DDR3 traffic checker.
//   - test_state_e : run state of the checker (IDLE/WRITE/READ/DONE).
//   - ERR_COUNT_W  : width of the saturating mismatch counter.
//   - PAT_W        : working width of the pattern helper.
//   - pattern_word : address-derived test word. Callers truncate the result
//                    to their data width.
package ddr3_test_pkg;

  localparam int ERR_COUNT_W = 16;
  localparam int PAT_W       = 64;

  // IDLE is encoded as zero so the reset state and the all-zero output
  // image coincide.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } test_state_e;

  // The address is zero-extended first and then optionally inverted.
  // With a narrow address and a wide data word, the upper data bits
  // therefore read as ones in inverted mode.
  function automatic logic [PAT_W-1:0] pattern_word(input logic [PAT_W-1:0] addr,
                                                    input logic             invert);
    return invert ? ~addr : addr;
  endfunction

endpackage

// File: rtl/ddr3_outstanding_tracker.sv
// Counts reads that have been issued to the controller but have not yet
// returned.
// Ports:
//   clk, resetn : clock and synchronous active-low reset
//   clear       : synchronous clear at the start of a run
//   issue       : a read command was accepted this cycle
//   retire      : a read response was consumed this cycle (caller only
//                 asserts it when not empty)
//   empty       : no reads in flight
//   full_next   : the count after this edge equals MAX_OUTSTANDING. The
//                 checker uses it to decide whether its registered
//                 read_enable may stay high.
module ddr3_outstanding_tracker #(
  parameter int MAX_OUTSTANDING = 4,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic issue,
  input  logic retire,
  output logic empty,
  output logic full_next
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else begin
      // A simultaneous issue and retire leaves the count unchanged.
      case ({issue, retire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) count_q <= '0;
    else         count_q <= count_d;
  end

  assign empty     = (count_q == '0);
  assign full_next = (count_d == CNT_W'(MAX_OUTSTANDING));

endmodule

// File: rtl/ddr3_traffic_checker.sv
// Handshaked write-then-read-back test engine for the DDR3 controller's
// user port.
//
// A run starts with `start` while the engine is idle or done. It writes
// NUM_WORDS address-derived words, then reads them back. Each returned word
// is compared against the expected pattern, and the engine reports
// pass/fail, a saturating error count, and the first failing address and
// data.
//
// Command handshake: a command (write_enable or read_enable, never both)
// transfers on a rising edge where its enable and ctrl_ready are both high.
// While an enable is high and ctrl_ready is low, the address and data are
// held unchanged. Read data transfers on any edge where rd_valid is high;
// responses arrive in issue order and there is no back-pressure.
//
// Ports:
//   clk, resetn         : clock and synchronous active-low reset
//   start, pattern_sel  : run request and pattern choice (0 addr, 1 ~addr)
//   busy, pass, fail    : run status
//   error_count         : saturating mismatch count
//   first_err_addr/data : address and returned data of the first mismatch
//   write_enable, read_enable, i_user_data_address, i_user_data : command
//                         request to the controller
//   ctrl_ready          : controller accepts the presented command
//   rd_valid, o_user_data : read response from the controller
//   dbg_state           : current run state (test_state_e encoding)
//
// All outputs are registered and reset to zero.
module ddr3_traffic_checker
  import ddr3_test_pkg::*;
#(
  parameter int ADDRESS_BITWIDTH      = 15,
  parameter int BANK_ADDRESS_BITWIDTH = 3,
  parameter int DQ_BITWIDTH           = 16,
  parameter int NUM_WORDS             = 256,
  parameter int MAX_OUTSTANDING       = 4
) (
  input  logic                                              clk,
  input  logic                                              resetn,
  input  logic                                              start,
  input  logic                                              pattern_sel,
  output logic                                              busy,
  output logic                                              pass,
  output logic                                              fail,
  output logic [ERR_COUNT_W-1:0]                            error_count,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_err_addr,
  output logic [DQ_BITWIDTH-1:0]                            first_err_data,
  output logic                                              write_enable,
  output logic                                              read_enable,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
  output logic [DQ_BITWIDTH-1:0]                            i_user_data,
  input  logic                                              ctrl_ready,
  input  logic                                              rd_valid,
  input  logic [DQ_BITWIDTH-1:0]                            o_user_data,
  output logic [1:0]                                        dbg_state
);

  localparam int A     = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
  // One extra bit so that a word index can reach NUM_WORDS == 2^A.
  localparam int CNT_W = A + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(NUM_WORDS);

  function automatic logic [DQ_BITWIDTH-1:0] pat(input logic [CNT_W-1:0] a,
                                                 input logic             inv);
    return DQ_BITWIDTH'(pattern_word(PAT_W'(a), inv));
  endfunction

  test_state_e             state_q, state_d;
  logic                    pattern_q, pattern_d;
  logic [CNT_W-1:0]        wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]        rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]        chk_addr_q, chk_addr_d;
  logic [ERR_COUNT_W-1:0]  error_count_q, error_count_d;
  logic [A-1:0]            first_err_addr_q, first_err_addr_d;
  logic [DQ_BITWIDTH-1:0]  first_err_data_q, first_err_data_d;
  logic                    busy_q, busy_d;
  logic                    pass_q, pass_d;
  logic                    fail_q, fail_d;
  logic                    write_enable_q, write_enable_d;
  logic                    read_enable_q, read_enable_d;
  logic [A-1:0]            cmd_addr_q, cmd_addr_d;
  logic [DQ_BITWIDTH-1:0]  cmd_data_q, cmd_data_d;

  logic start_run;
  logic wr_accept;
  logic rd_issue;
  logic rd_return;
  logic mismatch;
  logic out_empty;
  logic out_full_next;

  // start is only honoured when no run is in progress.
  assign start_run = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign wr_accept = (state_q == ST_WRITE) && write_enable_q && ctrl_ready;
  assign rd_issue  = (state_q == ST_READ) && read_enable_q && ctrl_ready;
  // Responses outside READ, or with nothing in flight, are stray and are
  // dropped without a compare.
  assign rd_return = (state_q == ST_READ) && rd_valid && !out_empty;
  assign mismatch  = (o_user_data != pat(chk_addr_q, pattern_q));

  ddr3_outstanding_tracker #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_tracker (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (start_run),
    .issue    (rd_issue),
    .retire   (rd_return),
    .empty    (out_empty),
    .full_next(out_full_next)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q          <= ST_IDLE;
      pattern_q        <= 1'b0;
      wr_addr_q        <= '0;
      rd_addr_q        <= '0;
      chk_addr_q       <= '0;
      error_count_q    <= '0;
      first_err_addr_q <= '0;
      first_err_data_q <= '0;
      busy_q           <= 1'b0;
      pass_q           <= 1'b0;
      fail_q           <= 1'b0;
      write_enable_q   <= 1'b0;
      read_enable_q    <= 1'b0;
      cmd_addr_q       <= '0;
      cmd_data_q       <= '0;
    end else begin
      state_q          <= state_d;
      pattern_q        <= pattern_d;
      wr_addr_q        <= wr_addr_d;
      rd_addr_q        <= rd_addr_d;
      chk_addr_q       <= chk_addr_d;
      error_count_q    <= error_count_d;
      first_err_addr_q <= first_err_addr_d;
      first_err_data_q <= first_err_data_d;
      busy_q           <= busy_d;
      pass_q           <= pass_d;
      fail_q           <= fail_d;
      write_enable_q   <= write_enable_d;
      read_enable_q    <= read_enable_d;
      cmd_addr_q       <= cmd_addr_d;
      cmd_data_q       <= cmd_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_run) state_d = ST_WRITE;
      ST_WRITE:         if (wr_accept && wr_addr_q == LAST_IDX) state_d = ST_READ;
      ST_READ:          if (rd_return && chk_addr_q == LAST_IDX) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Next values of the datapath and of the registered outputs
  always_comb begin
    pattern_d        = pattern_q;
    wr_addr_d        = wr_addr_q;
    rd_addr_d        = rd_addr_q;
    chk_addr_d       = chk_addr_q;
    error_count_d    = error_count_q;
    first_err_addr_d = first_err_addr_q;
    first_err_data_d = first_err_data_q;
    busy_d           = busy_q;
    pass_d           = pass_q;
    fail_d           = fail_q;
    write_enable_d   = write_enable_q;
    read_enable_d    = read_enable_q;
    cmd_addr_d       = cmd_addr_q;
    cmd_data_d       = cmd_data_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_run) begin
          pattern_d        = pattern_sel;
          wr_addr_d        = '0;
          rd_addr_d        = '0;
          chk_addr_d       = '0;
          error_count_d    = '0;
          first_err_addr_d = '0;
          first_err_data_d = '0;
          busy_d           = 1'b1;
          pass_d           = 1'b0;
          fail_d           = 1'b0;
          write_enable_d   = 1'b1;
          read_enable_d    = 1'b0;
          cmd_addr_d       = '0;
          cmd_data_d       = pat('0, pattern_sel);
        end
      end

      ST_WRITE: begin
        if (wr_accept) begin
          wr_addr_d = wr_addr_q + CNT_W'(1);
          if (wr_addr_q == LAST_IDX) begin
            // Hand over straight to reading. rd_addr is 0 and nothing is
            // in flight, so the first read can be requested immediately.
            write_enable_d = 1'b0;
            read_enable_d  = 1'b1;
            cmd_addr_d     = '0;
          end else begin
            cmd_addr_d = wr_addr_d[A-1:0];
            cmd_data_d = pat(wr_addr_d, pattern_q);
          end
        end
      end

      ST_READ: begin
        if (rd_issue) rd_addr_d = rd_addr_q + CNT_W'(1);
        if (rd_return) begin
          chk_addr_d = chk_addr_q + CNT_W'(1);
          if (mismatch) begin
            if (error_count_q != '1) error_count_d = error_count_q + ERR_COUNT_W'(1);
            // The count saturates and never returns to zero within a run,
            // so zero here means this is the first mismatch.
            if (error_count_q == '0) begin
              first_err_addr_d = chk_addr_q[A-1:0];
              first_err_data_d = o_user_data;
            end
          end
          if (chk_addr_q == LAST_IDX) begin
            busy_d = 1'b0;
            pass_d = (error_count_d == '0);
            fail_d = (error_count_d != '0);
          end
        end
        // read_enable is registered, so it is computed from the counts as
        // they will stand after this edge.
        read_enable_d = (state_d == ST_READ) && (rd_addr_d < WORD_CNT) && !out_full_next;
        cmd_addr_d    = rd_addr_d[A-1:0];
      end

      default: ;
    endcase
  end

  assign busy                = busy_q;
  assign pass                = pass_q;
  assign fail                = fail_q;
  assign error_count         = error_count_q;
  assign first_err_addr      = first_err_addr_q;
  assign first_err_data      = first_err_data_q;
  assign write_enable        = write_enable_q;
  assign read_enable         = read_enable_q;
  assign i_user_data_address = cmd_addr_q;
  assign i_user_data         = cmd_data_q;
  assign dbg_state           = state_q;

endmodule

// File: doc/ddr3_traffic_checker.md
# ddr3_traffic_checker

Self-checking traffic generator sitting directly upstream of `ddr3_memory_controller`. It drives the controller's user write/read port with a deterministic address-derived pattern over a configurable address range, then reads the range back, compares every returned word, and reports pass/fail, an error count and the first failing address and data. It replaces free-running loopback logic in board tops with a handshaked, restartable test engine.

## Interface
- `ADDRESS_BITWIDTH`, 15, DDR3 row/column address width.
- `BANK_ADDRESS_BITWIDTH`, 3, bank address width.
- `DQ_BITWIDTH`, 16, user data width (even, ≥ 8).
- `NUM_WORDS`, 256, words written then read per run (1 .. 2^(BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH)).
- `MAX_OUTSTANDING`, 4, maximum reads issued but not yet returned (≥ 1).

Ports (A = BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH):
- `clk` in 1, the single clock; all logic on its rising edge.
- `resetn` in 1, synchronous, active-low reset.
- `start` in 1, pulse; starts a run when not busy.
- `pattern_sel` in 1, 0 = data is address, 1 = data is inverted address; sampled on accepted `start`.
- `busy` out 1, run in progress.
- `pass` out 1, last run finished with zero errors.
- `fail` out 1, last run finished with ≥ 1 error.
- `error_count` out 16, mismatches in current/last run, saturating.
- `first_err_addr` out A, address of first mismatch.
- `first_err_data` out DQ_BITWIDTH, data returned at first mismatch.
- `write_enable` out 1, write command request to controller.
- `read_enable` out 1, read command request to controller.
- `i_user_data_address` out A, command address.
- `i_user_data` out DQ_BITWIDTH, write data.
- `ctrl_ready` in 1, controller accepts the presented command this cycle.
- `rd_valid` in 1, `o_user_data` carries read data this cycle.
- `o_user_data` in DQ_BITWIDTH, read data from controller.

## Operation
- States: IDLE, WRITE, READ, DONE.
- IDLE: all command outputs low. `start` → WRITE; clears error_count, first_err_*, pass, fail; latches pattern_sel; wr_addr = rd_addr = chk_addr = 0, outstanding = 0.
- Pattern: p(a) = a[DQ_BITWIDTH-1:0] zero-extended if A < DQ_BITWIDTH; inverted bitwise when latched pattern_sel = 1.
- WRITE: write_enable = 1, address = wr_addr, data = p(wr_addr). Accept = write_enable & ctrl_ready; on accept wr_addr+1. After accept of word NUM_WORDS-1 → READ, write_enable low next cycle.
- READ: read_enable = 1 while rd_addr < NUM_WORDS and outstanding < MAX_OUTSTANDING; address = rd_addr. Accept increments rd_addr and outstanding; rd_valid decrements outstanding; both same cycle → unchanged.
- Reads return in issue order. On rd_valid: compare o_user_data with p(chk_addr); mismatch → error_count+1 (saturate at 0xFFFF); if first mismatch, capture chk_addr and o_user_data. chk_addr+1.
- After rd_valid for word NUM_WORDS-1 → DONE; pass = (error_count==0 including this compare), fail = ~pass.
- DONE: outputs held; `start` restarts as from IDLE.
- `start` while busy ignored. rd_valid outside READ ignored. rd_valid with outstanding = 0 in READ ignored (no compare).
- write_enable and read_enable never high together.

## Timing
- All outputs registered; reset value of every output 0 (state IDLE).
- `start` at edge n → write_enable high from cycle n+1.
- Command outputs stable while enable high and ctrl_ready low.
- Last write accept at cycle m → read_enable high at m+1.
- pass/fail/busy update the cycle after the final rd_valid; busy = 1 in WRITE and READ only.
- resetn low mid-run: next edge returns to IDLE, outstanding discarded, all outputs 0.

## Structure
- Package `ddr3_test_pkg`: state enum, p() pattern function, ERR_COUNT_W = 16.
- Sub-module `ddr3_outstanding_tracker`: outstanding read counter with issue/return/full flag.

## Test plan
- NUM_WORDS=8, ctrl_ready tied 1, ideal memory model → 8 writes data 0..7, 8 reads, pass=1, error_count=0.
- ctrl_ready toggling 1-of-3 cycles → address/data held while stalled, still pass=1.
- Model corrupts address 5 to 0xDEAD → fail=1, error_count=1, first_err_addr=5, first_err_data=0xDEAD.
- Read latency 10 cycles, MAX_OUTSTANDING=4 → never more than 4 unreturned reads; pass=1.
- pattern_sel=1 → write data at address 3 = 0xFFFC; `start` during run ignored; restart from DONE clears error_count.
- resetn low during READ → next cycle all outputs 0, state IDLE; fresh start passes.
